// File: rtl/api_chip_resp.sv
// Chip-side responder for the miner serial link: receives work words, returns header + queued nonces.
// Optional watchdog abort on a stalled frame is enabled by defining API_CHIP_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no frame; miso low; waits for load rise (or one held from S_END)
// S_SHIFT | frame active; shifting rx on sck rise, tx on sck fall
// S_END   | one cycle; reports work_done or frame_err

module api_chip_resp #(
    parameter int WORK_LEN    = 23,
    parameter int NONCE_DEPTH = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        load,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] work_dout,
    output logic        work_wr,
    output logic        work_done,
    output logic        frame_err,
    input  logic [31:0] nonce_din,
    input  logic        nonce_push,
    output logic        nonce_full,
    output logic        nonce_ovf
);

    localparam int AW = $clog2(NONCE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(NONCE_DEPTH);
    localparam logic [7:0]    WLEN_C  = 8'(WORK_LEN);

    if (NONCE_DEPTH < 2 || NONCE_DEPTH > 64 || (NONCE_DEPTH & (NONCE_DEPTH - 1)) != 0
        || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("api_chip_resp: illegal NONCE_DEPTH or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;
    state_t state, state_n;

    logic [2:0]  load_q, sck_q;
    logic [1:0]  mosi_q;
    logic        load_rise, load_fall, sck_rise, sck_fall;
    logic        load_pend, start, at_boundary, pop, push_ok, timeout;
    logic [4:0]  bit_cnt;
    logic [7:0]  word_cnt, snap, snap_n, popped;
    logic [30:0] rx_sr;
    logic [31:0] tx_sr;

    logic [31:0]   mem [NONCE_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_n;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            load_q <= '0;
            sck_q  <= '0;
            mosi_q <= '0;
        end else begin
            load_q <= {load_q[1:0], load};
            sck_q  <= {sck_q[1:0], sck};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign load_rise   = load_q[1] & ~load_q[2];
    assign load_fall   = ~load_q[1] & load_q[2];
    assign sck_rise    = sck_q[1] & ~sck_q[2];
    assign sck_fall    = ~sck_q[1] & sck_q[2];
    assign start       = (state == S_IDLE) && (load_rise || load_pend);
    assign at_boundary = (bit_cnt == 5'd0) && (word_cnt != 8'd0);
    assign pop         = (state == S_SHIFT) && sck_fall && at_boundary
                         && (popped < snap) && (cnt != '0);
    assign push_ok     = nonce_push && (!nonce_full || pop);
    // Depth is capped at 64, so the count always fits the 8-bit header field.
    assign snap_n      = 8'(cnt);
    assign miso        = (state == S_SHIFT) ? tx_sr[31] : 1'b0;

`ifdef API_CHIP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_C = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] wd_cnt;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            wd_cnt <= '0;
        else if (start || sck_rise || sck_fall)
            wd_cnt <= TO_C;
        else if (state == S_SHIFT && wd_cnt != '0)
            wd_cnt <= wd_cnt - 1'b1;
    end

    assign timeout = (state == S_SHIFT) && !sck_rise && !sck_fall && (wd_cnt == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (load_rise || load_pend) state_n = S_SHIFT;
            S_SHIFT: begin
                if (load_fall)    state_n = S_END;
                else if (timeout) state_n = S_IDLE;
            end
            S_END:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            load_pend <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            snap      <= '0;
            popped    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            work_dout <= '0;
            work_wr   <= 1'b0;
            work_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            work_wr   <= 1'b0;
            work_done <= 1'b0;
            frame_err <= 1'b0;
            if (state == S_END && load_rise)
                load_pend <= 1'b1;
            else if (state == S_IDLE)
                load_pend <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    popped   <= '0;
                    rx_sr    <= '0;
                    snap     <= snap_n;
                    tx_sr    <= {16'hA55A, 8'h00, snap_n};
                end
                S_SHIFT: begin
                    if (sck_rise) begin
                        rx_sr   <= {rx_sr[29:0], mosi_q[1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 5'd31) begin
                            if (word_cnt < WLEN_C) begin
                                work_dout <= {rx_sr, mosi_q[1]};
                                work_wr   <= 1'b1;
                            end
                            if (word_cnt != 8'hFF)
                                word_cnt <= word_cnt + 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        if (at_boundary) begin
                            tx_sr <= pop ? mem[rd_ptr] : 32'h0;
                            if (pop) popped <= popped + 1'b1;
                        end else begin
                            tx_sr <= {tx_sr[30:0], 1'b0};
                        end
                    end
                    if (timeout && !load_fall)
                        frame_err <= 1'b1;
                end
                S_END: begin
                    if (word_cnt == WLEN_C && bit_cnt == 5'd0) work_done <= 1'b1;
                    else                                       frame_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_n = cnt;
        case ({push_ok, pop})
            2'b10:   cnt_n = cnt + 1'b1;
            2'b01:   cnt_n = cnt - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (push_ok) mem[wr_ptr] <= nonce_din;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            nonce_full <= 1'b0;
            nonce_ovf  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            cnt        <= cnt_n;
            nonce_full <= (cnt_n == DEPTH_C);
            nonce_ovf  <= nonce_push && nonce_full && !pop;
        end
    end

endmodule

// File: tb/tb_api_chip_resp.sv
// Scoreboard bench for api_chip_resp: stimulus queues expected words/events, monitors pop and compare.
module tb_api_chip_resp;

`ifdef API_CHIP_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 4096;
`endif

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        load = 1'b0, sck = 1'b0, mosi = 1'b0;
    logic        miso;
    logic [31:0] work_dout;
    logic        work_wr, work_done, frame_err;
    logic [31:0] nonce_din = '0;
    logic        nonce_push = 1'b0;
    logic        nonce_full, nonce_ovf;

    api_chip_resp #(.WORK_LEN(23), .NONCE_DEPTH(8), .TIMEOUT_CYC(TO)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .load(load), .sck(sck), .mosi(mosi), .miso(miso),
        .work_dout(work_dout), .work_wr(work_wr), .work_done(work_done), .frame_err(frame_err),
        .nonce_din(nonce_din), .nonce_push(nonce_push), .nonce_full(nonce_full),
        .nonce_ovf(nonce_ovf)
    );

    always #5 CLK_I = ~CLK_I;

    int          n_tests = 0, n_fail = 0, ovf_cnt = 0, mbits = 0;
    bit          miso_chk = 1'b1;
    logic [31:0] exp_work[$], exp_miso[$], none[$], nq[$];
    logic [1:0]  exp_evt[$];
    logic [31:0] msr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // output monitor for the word/event interface
    always @(negedge CLK_I) begin
        if (!RST_I) begin
            if (work_wr) begin
                if (exp_work.size() == 0) unexpected("work_wr", work_dout);
                else check("work_dout", work_dout, exp_work.pop_front());
            end
            if (work_done || frame_err) begin
                if (exp_evt.size() == 0) unexpected("frame_evt", {30'd0, work_done, frame_err});
                else check("frame_evt", {30'd0, work_done, frame_err}, {30'd0, exp_evt.pop_front()});
            end
            if (nonce_ovf) ovf_cnt++;
        end
    end

    // miso monitor: the host samples on the sck rising edge
    always @(posedge load) mbits = 0;
    always @(posedge sck) begin
        if (load && miso_chk) begin
            msr = {msr[30:0], miso};
            mbits++;
            if (mbits == 32) begin
                mbits = 0;
                if (exp_miso.size() == 0) unexpected("miso_word", msr);
                else check("miso_word", msr, exp_miso.pop_front());
            end
        end
    end

    task automatic clk(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int b = 31; b > 31 - n; b--) begin
            mosi = w[b];
            clk(5);
            sck = 1'b1;
            clk(5);
            sck = 1'b0;
        end
    endtask

    task automatic frame(input int nwords, input int nbits, input logic [31:0] base,
                         input logic [31:0] q[$]);
        for (int i = 0; i < nwords && i < 23; i++) exp_work.push_back(base + 32'(i));
        exp_evt.push_back((nwords == 23 && nbits == 0) ? 2'b10 : 2'b01);
        for (int i = 0; i < nwords; i++) begin
            if (i == 0)              exp_miso.push_back({16'hA55A, 8'h00, 8'(q.size())});
            else if (i - 1 < q.size()) exp_miso.push_back(q[i-1]);
            else                     exp_miso.push_back(32'h0);
        end
        load = 1'b1;
        clk(8);
        for (int i = 0; i < nwords; i++) send_bits(base + 32'(i), 32);
        if (nbits > 0) send_bits(base + 32'(nwords), nbits);
        clk(8);
        load = 1'b0;
        clk(16);
    endtask

    task automatic push_nonce(input logic [31:0] v);
        nonce_din  = v;
        nonce_push = 1'b1;
        clk(1);
        nonce_push = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        clk(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_work_dout", work_dout, 32'd0);
        check("rst_pulses", {28'd0, work_wr, work_done, frame_err, nonce_ovf}, 32'd0);
        check("rst_full", {31'd0, nonce_full}, 32'd0);
        RST_I = 1'b0;
        clk(4);

        // 23 words, empty FIFO
        frame(23, 0, 32'h0000_0000, none);

        // two nonces returned after the header
        nq = {32'hDEAD_BEEF, 32'h1234_5678};
        push_nonce(nq[0]);
        push_nonce(nq[1]);
        check("two_push_full", {31'd0, nonce_full}, 32'd0);
        frame(23, 0, 32'h2000_0000, nq);

        // short frame (FIFO must be empty again: header count 0)
        frame(22, 5, 32'h3000_0000, none);

        // long frame: only 23 words delivered
        frame(25, 0, 32'h4000_0000, none);

        // overfill the FIFO
        nq.delete();
        for (int k = 1; k <= 9; k++) begin
            push_nonce(32'h5000_0000 + 32'(k));
            if (k <= 8) nq.push_back(32'h5000_0000 + 32'(k));
            check($sformatf("full_after_push%0d", k), {31'd0, nonce_full}, {31'd0, k >= 8});
            check($sformatf("ovf_after_push%0d", k), {31'd0, nonce_ovf}, {31'd0, k == 9});
        end
        frame(23, 0, 32'h0100_0000, nq);
        check("full_after_drain", {31'd0, nonce_full}, 32'd0);

`ifdef API_CHIP_TIMEOUT_EN
        // stalled frame aborts; later edges ignored until load toggles
        miso_chk = 1'b0;
        exp_evt.push_back(2'b01);
        load = 1'b1;
        clk(8);
        send_bits(32'hFFC0_0000, 10);
        clk(TO + 20);
        check("timeout_miso", {31'd0, miso}, 32'd0);
        send_bits(32'hAAAA_AAAA, 32);
        clk(8);
        load = 1'b0;
        clk(16);
        miso_chk = 1'b1;
`endif

        // reset mid-word: one completed word, then nothing
        exp_work.push_back(32'hC0DE_0000);
        exp_miso.push_back(32'hA55A_0000);
        load = 1'b1;
        clk(8);
        send_bits(32'hC0DE_0000, 32);
        send_bits(32'hC0DE_0001, 8);
        RST_I = 1'b1;
        clk(1);
        load = 1'b0;
        clk(2);
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_pulses", {29'd0, work_wr, work_done, frame_err}, 32'd0);
        RST_I = 1'b0;
        clk(16);
        frame(23, 0, 32'hC0DE_0100, none);

        clk(20);
        check("work_q_empty", 32'(exp_work.size()), 32'd0);
        check("evt_q_empty", 32'(exp_evt.size()), 32'd0);
        check("miso_q_empty", 32'(exp_miso.size()), 32'd0);
        check("ovf_total", 32'(ovf_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/api_chip_resp.md
Name: api_chip_resp

Overview:
- Chip-side responder for the miner serial link (load/sck/mosi/miso).
- Models one miner ASIC endpoint so the host-side controller can be tested, and is usable as an FPGA-hosted chip emulator.
- Deserialises WORK_LEN 32-bit work words from mosi and presents them on a word interface.
- In the same frame, serialises a header and queued nonces on miso.

Parameters:
- WORK_LEN, 23, 32-bit words per valid work frame.
- NONCE_DEPTH, 8, depth of the local nonce FIFO; power of 2, 2..64.
- TIMEOUT_CYC, 4096, watchdog limit in CLK_I cycles; used only with API_CHIP_TIMEOUT_EN.

Ports:
- CLK_I  in  1  system clock; must be at least 4x sck frequency.
- RST_I  in  1  asynchronous, active-high reset.
- load  in  1  chip select; high = frame active. Asynchronous to CLK_I.
- sck  in  1  serial clock; idle low. Asynchronous to CLK_I.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- work_dout  out  32  last completed received word.
- work_wr  out  1  1-cycle pulse; work_dout valid.
- work_done  out  1  1-cycle pulse; frame ended with exactly WORK_LEN whole words.
- frame_err  out  1  1-cycle pulse; frame ended malformed.
- nonce_din  in  32  nonce to queue.
- nonce_push  in  1  push nonce_din.
- nonce_full  out  1  FIFO holds NONCE_DEPTH entries.
- nonce_ovf  out  1  1-cycle pulse; push dropped because FIFO full.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; all counters 0.
- Synchronisation:
  - load, sck, mosi each pass through 2-flop synchronisers, plus a third flop on load and sck for edge detection.
  - Edge detection occurs 3 cycles after the pin change.
  - mosi is sampled from its synchronised value in the sck-rise detect cycle.
- States: IDLE, SHIFT, END.
- IDLE:
  - miso = 0.
  - On load-rise detect:
    - bit_cnt = 0, word_cnt = 0.
    - snap = min(FIFO count, 255).
    - Load tx_sr = {16'hA55A, 8'h00, snap[7:0]}; miso = tx_sr[31] the next cycle.
    - Go to SHIFT.
- SHIFT, sck-rise detect:
  - rx_sr = {rx_sr[30:0], mosi_s}; bit_cnt++.
  - When bit_cnt wraps 31->0:
    - If word_cnt < WORK_LEN: work_dout = new word, work_wr pulses the next cycle.
    - Otherwise the word is discarded.
    - word_cnt increments, saturating at 255.
- SHIFT, sck-fall detect:
  - If not at a word boundary: tx_sr <<= 1.
  - At a word boundary (bit_cnt==0 after a completed word):
    - Load the next tx word: FIFO head with a pop if popped-this-frame < snap, else 32'h0.
  - miso = tx_sr[31] after the update.
- SHIFT, load-fall detect: go to END.
- END, one cycle:
  - work_done if word_cnt == WORK_LEN && bit_cnt == 0; else frame_err. Never both.
  - miso = 0; go to IDLE.
- Simultaneous sck edge and load fall in the same detect cycle: process the sck edge first, then END.
- A load rise while in END is held and acted on in the following IDLE cycle.
- Nonce FIFO:
  - Push when not full.
  - Push while full: dropped, nonce_ovf pulses.
  - Pop and push in the same cycle while full: both accepted; count unchanged.
  - Popped nonces are not restored if the frame later errors.
- nonce_full is registered and reflects the count after the cycle's push/pop.
- Reset mid-frame: everything returns to IDLE/reset values; no work_done/frame_err pulse is emitted.

Optional Feature:
- Macro: API_CHIP_TIMEOUT_EN.
- With it: in SHIFT, a watchdog counts CLK_I cycles since the last sck edge or load rise. At TIMEOUT_CYC:
  - Abort the frame, pulse frame_err, miso = 0.
  - Enter IDLE and ignore further sck edges until load-fall then a new load-rise.
- Without it: no counter; SHIFT persists indefinitely while load is high.

Test Plan:
- Frame of 23 words 32'h0000_0000..32'h0000_0016, no nonces -> 23 work_wr pulses with matching work_dout; 1 work_done; miso word0 = 32'hA55A_0000, words 1..22 = 0.
- Push 32'hDEAD_BEEF and 32'h1234_5678, then a 23-word frame -> miso word0 = 32'hA55A_0002, word1 = DEADBEEF, word2 = 12345678, rest 0; FIFO empty at end.
- Frame of 22 words + 5 bits, then load low -> 22 work_wr pulses, frame_err = 1, work_done = 0.
- Frame of 25 words -> exactly 23 work_wr pulses; frame_err at end.
- Push 9 nonces with NONCE_DEPTH=8 -> nonce_full=1 after the 8th push; nonce_ovf pulses once on the 9th; header count = 8.
- API_CHIP_TIMEOUT_EN, TIMEOUT_CYC=64: load high, 10 sck edges, then sck stalls -> frame_err after 64 cycles; later edges ignored until load toggles.
- RST_I pulsed mid-word -> miso = 0, no pulses; the next full frame completes normally.
